// File: rtl/wb_pkg.sv
// Shared types for the regfile writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // One queued regfile write.
   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      WB_NORMAL,
      WB_FORCE
   } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of pending LSU writebacks, exposing per-slot valid/rd for hazard lookup.
// Latency: a push is visible at head and in slot_vld one cycle later.
// Backpressure: full blocks push, empty blocks pop; both are ignored rather than corrupting state.
// Ports: clk, reset_n | push, push_entry | pop, head | full, empty | slot_vld, slot_rd
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        push,
   input  wb_entry_t                   push_entry,
   input  logic                        pop,
   output wb_entry_t                   head,
   output logic                        full,
   output logic                        empty,
   output logic [DEPTH-1:0]            slot_vld,
   output logic [DEPTH-1:0][REG_W-1:0] slot_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy is defined solely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset   = '0;
      slot_vld = '0;
      slot_rd  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset      = PTR_W'(i) - rd_ptr;
         slot_vld[i] = ({1'b0, offset} < count);
         slot_rd[i]  = mem[i].rd;
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and queued LSU writebacks onto the single regfile write port; ALU has priority.
// Latency: the winning write appears on rf_* one cycle after selection.
// Backpressure: lsu_ready=0 when the FIFO is full; alu_stall=1 for one cycle to force-drain a starved FIFO head.
// Ports: clk, reset_n | alu_valid/rd/data, alu_stall | lsu_valid/ready/rd/data
//        rd_addr1/2 -> pend_hit1/2 | rf_we, rf_waddr, rf_wdata
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   input  logic [REG_W-1:0]  alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_stall,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_W-1:0]  lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   input  logic [REG_W-1:0]  rd_addr1,
   input  logic [REG_W-1:0]  rd_addr2,
   output logic              pend_hit1,
   output logic              pend_hit2,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX - 1);

   wb_state_e               state;
   logic [CNT_W-1:0]        starve_cnt;
   wb_entry_t               head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    alu_win;
   logic [DEPTH-1:0]        slot_vld;
   logic [DEPTH-1:0][REG_W-1:0] slot_rd;

   // Writes to $zero are accepted and silently dropped on both streams.
   assign alu_win   = (state == WB_NORMAL) && alu_valid && (alu_rd != REG_ZERO);
   assign fifo_push = lsu_valid && !fifo_full && (lsu_rd != REG_ZERO);
   assign fifo_pop  = !fifo_empty && ((state == WB_FORCE) || !alu_win);
   assign lsu_ready = !fifo_full;
   assign alu_stall = (state == WB_FORCE);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (fifo_push),
      .push_entry ('{rd: lsu_rd, data: lsu_data}),
      .pop        (fifo_pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .slot_vld   (slot_vld),
      .slot_rd    (slot_rd)
   );

   // Hazard lookup against queued LSU writes; the head being popped this cycle still counts.
   always_comb begin
      logic hit1;
      logic hit2;
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit1 = hit1 | (slot_vld[i] && (slot_rd[i] == rd_addr1));
         hit2 = hit2 | (slot_vld[i] && (slot_rd[i] == rd_addr2));
      end
      pend_hit1 = hit1 && (rd_addr1 != REG_ZERO);
      pend_hit2 = hit2 && (rd_addr2 != REG_ZERO);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= WB_NORMAL;
         starve_cnt <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         case (state)
            WB_NORMAL: begin
               if (alu_win) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= alu_rd;
                  rf_wdata <= alu_data;
                  if (fifo_empty) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt == STARVE_LIM) begin
                     // Head has lost STARVE_MAX times in a row: stall ALU next cycle.
                     state      <= WB_FORCE;
                     starve_cnt <= '0;
                  end else begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end else if (!fifo_empty) begin
                  rf_we      <= 1'b1;
                  rf_waddr   <= head.rd;
                  rf_wdata   <= head.data;
                  starve_cnt <= '0;
               end else begin
                  rf_we      <= 1'b0;
                  starve_cnt <= '0;
               end
            end
            WB_FORCE: begin
               rf_we <= !fifo_empty;
               if (!fifo_empty) begin
                  rf_waddr <= head.rd;
                  rf_wdata <= head.data;
               end
               starve_cnt <= '0;
               state      <= WB_NORMAL;
            end
            default: begin
               state <= WB_NORMAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboarded bench for wb_write_arbiter: directed stimulus queues expected regfile writes,
// a negedge monitor pops and compares every rf_we pulse; cycle-exact flags checked inline.
module tb_wb_write_arbiter;
   import wb_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              alu_valid;
   logic [REG_W-1:0]  alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_stall;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [REG_W-1:0]  lsu_rd;
   logic [DATA_W-1:0] lsu_data;
   logic [REG_W-1:0]  rd_addr1;
   logic [REG_W-1:0]  rd_addr2;
   logic              pend_hit1;
   logic              pend_hit2;
   logic              rf_we;
   logic [REG_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   int          tests = 0;
   int          fails = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;
   int          idx;

   always #5 clk = ~clk;

   wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_stall (alu_stall),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .pend_hit1 (pend_hit1),
      .pend_hit2 (pend_hit2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({rd, d});
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lsu_valid = v;
      lsu_rd    = rd;
      lsu_data  = d;
   endtask

   // Monitor: every regfile write must match the next expected write, in order.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write at %0t",
                     rf_waddr, rf_wdata, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rf_waddr", 32'(rf_waddr), 32'(mon_e[36:32]));
            chk("rf_wdata", rf_wdata, mon_e[31:0]);
         end
      end
   end

   initial begin
      // ---- 1: reset with LSU offering ----
      reset_n  = 1'b0;
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b1, 5'd3, 32'h3333_3333);
      rd_addr1 = 5'd3;
      rd_addr2 = 5'd0;
      repeat (3) step();
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("reset_alu_stall", 32'(alu_stall), 32'd0);
      chk("reset_pend_hit1", 32'(pend_hit1), 32'd0);
      lsu_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("post_reset_rf_we", 32'(rf_we), 32'd0);
      chk("post_reset_pend_hit1", 32'(pend_hit1), 32'd0);

      // ---- 2: ALU only, then $zero writes on both streams ----
      drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
      expect_wr(5'd5, 32'hDEAD_BEEF);
      step();
      chk("alu_rf_we", 32'(rf_we), 32'd1);
      chk("alu_rf_waddr", 32'(rf_waddr), 32'd5);
      drive_alu(1'b1, 5'd0, 32'h1234_5678);
      drive_lsu(1'b1, 5'd0, 32'h0000_0BAD);
      step();
      chk("zero_alu_rf_we", 32'(rf_we), 32'd0);
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu(1'b0, 5'd0, 32'h0);
      step();
      chk("zero_lsu_rf_we", 32'(rf_we), 32'd0);

      // ---- 3: contention, LSU rd=7 behind 3 ALU writes ----
      drive_alu(1'b1, 5'd10, 32'h0A0A_0010);
      drive_lsu(1'b1, 5'd7, 32'h7777_7777);
      expect_wr(5'd10, 32'h0A0A_0010);
      step();
      lsu_valid = 1'b0;
      drive_alu(1'b1, 5'd11, 32'h0A0A_0011);
      expect_wr(5'd11, 32'h0A0A_0011);
      rd_addr1 = 5'd7;
      rd_addr2 = 5'd7;
      #1;
      chk("pend_hit1_queued", 32'(pend_hit1), 32'd1);
      chk("pend_hit2_queued", 32'(pend_hit2), 32'd1);
      step();
      drive_alu(1'b1, 5'd12, 32'h0A0A_0012);
      expect_wr(5'd12, 32'h0A0A_0012);
      #1;
      chk("pend_hit1_waiting", 32'(pend_hit1), 32'd1);
      step();
      alu_valid = 1'b0;
      expect_wr(5'd7, 32'h7777_7777);
      #1;
      chk("pend_hit1_popping", 32'(pend_hit1), 32'd1);
      step();
      chk("lsu_rf_waddr", 32'(rf_waddr), 32'd7);
      chk("pend_hit1_after_pop", 32'(pend_hit1), 32'd0);
      rd_addr1 = 5'd0;
      #1;
      chk("pend_hit1_zero", 32'(pend_hit1), 32'd0);

      // ---- 4: fill to full with ALU busy, drain, then 6 more across the wrap ----
      for (int i = 0; i < 4; i++) begin
         drive_alu(1'b1, 5'(20 + i), 32'hA100_0000 + 32'(i));
         drive_lsu(1'b1, 5'(1 + i), 32'hC0DE_0000 + 32'(i));
         expect_wr(5'(20 + i), 32'hA100_0000 + 32'(i));
         step();
      end
      drive_alu(1'b0, 5'd0, 32'h0);
      lsu_valid = 1'b0;
      rd_addr1  = 5'd4;
      #1;
      chk("full_lsu_ready", 32'(lsu_ready), 32'd0);
      chk("full_pend_hit1", 32'(pend_hit1), 32'd1);
      for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'hC0DE_0000 + 32'(i));
      step();
      chk("drain_lsu_ready", 32'(lsu_ready), 32'd1);
      repeat (3) step();
      for (int i = 0; i < 6; i++) begin
         drive_lsu(1'b1, 5'(11 + i), 32'h5A00_0000 + 32'(i) * 32'h0101_0101);
         expect_wr(5'(11 + i), 32'h5A00_0000 + 32'(i) * 32'h0101_0101);
         step();
      end
      lsu_valid = 1'b0;
      repeat (3) step();

      // ---- 5: starvation guard ----
      for (int k = 0; k < 9; k++) expect_wr(5'(1 + k), 32'hA500_0000 + 32'(k));
      expect_wr(5'd30, 32'h5EED_5EED);
      expect_wr(5'd10, 32'hA500_0009);
      expect_wr(5'd11, 32'hA500_000A);
      idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         chk("starve_alu_stall", 32'(alu_stall), 32'(cyc == 9));
         if (cyc == 10) chk("starve_forced_waddr", 32'(rf_waddr), 32'd30);
         drive_alu(1'b1, 5'(1 + idx), 32'hA500_0000 + 32'(idx));
         if (cyc == 0) drive_lsu(1'b1, 5'd30, 32'h5EED_5EED);
         else          lsu_valid = 1'b0;
         if (!alu_stall) idx++;
         step();
      end
      alu_valid = 1'b0;
      repeat (2) step();

      // ---- 6: async reset mid-drain with 3 queued ----
      for (int i = 0; i < 3; i++) begin
         drive_alu(1'b1, 5'(2 + i), 32'h6600_0000 + 32'(i));
         drive_lsu(1'b1, 5'(21 + i), 32'h6B00_0000 + 32'(i));
         expect_wr(5'(2 + i), 32'h6600_0000 + 32'(i));
         step();
      end
      drive_alu(1'b0, 5'd0, 32'h0);
      lsu_valid = 1'b0;
      expect_wr(5'd21, 32'h6B00_0000);
      step();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_reset_rf_we", 32'(rf_we), 32'd0);
      chk("async_reset_lsu_ready", 32'(lsu_ready), 32'd1);
      rd_addr1 = 5'd22;
      #1;
      chk("async_reset_pend_hit1", 32'(pend_hit1), 32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (6) step();
      chk("post_reset_pend_hit1_22", 32'(pend_hit1), 32'd0);

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
